// File: rtl/key_locked_mem.sv
// Word-addressed memory whose key slots are provisioned after reset and are then write-protected.
// Blocked key writes and out-of-range accesses raise one-cycle pulses; blocked writes are counted.
module key_locked_mem #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned DEPTH        = 32,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned NUM_KEYS     = 2,
  parameter int unsigned KEY_BASE     = 0,
  parameter logic [NUM_KEYS*DATA_W-1:0] KEY_VALUES = {32'hA5A5_0F0F, 32'h1035_9987},
  parameter int unsigned KEY_READABLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              we,
  input  logic [DATA_W-1:0] wd,
  output logic [DATA_W-1:0] data_out,
  output logic              ready,
  output logic              lock_violation,
  output logic              addr_err,
  output logic [7:0]        violation_count
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned KpW  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam logic [IdxW:0] KeyLo   = (IdxW+1)'(KEY_BASE);
  localparam logic [IdxW:0] NumKeys = (IdxW+1)'(NUM_KEYS);

  typedef enum logic [1:0] {StClear, StProv, StReady} state_e;

  state_e            r_state, w_state_next;
  logic [IdxW-1:0]   r_clr_ptr, w_clr_ptr_next;
  logic [KpW-1:0]    r_key_ptr, w_key_ptr_next;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [IdxW-1:0]   w_idx;
  logic [IdxW:0]     w_key_off;
  logic              w_oor;
  logic              w_is_key;
  logic              w_mem_we;
  logic [IdxW-1:0]   w_mem_waddr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_unused_addr_lsb;

  assign w_idx             = address[IdxW+1:2];
  assign w_unused_addr_lsb = ^address[1:0];
  // Offset wraps to a large value below KEY_BASE, so one compare covers both bounds.
  assign w_key_off         = {1'b0, w_idx} - KeyLo;
  assign w_is_key          = (w_key_off < NumKeys);
  assign ready             = (r_state == StReady);

  generate
    if (ADDR_W > IdxW + 2) begin : g_oor
      assign w_oor = |address[ADDR_W-1:IdxW+2];
    end else begin : g_no_oor
      assign w_oor = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= StClear;
      r_clr_ptr <= '0;
      r_key_ptr <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_ptr <= w_clr_ptr_next;
      r_key_ptr <= w_key_ptr_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_clr_ptr_next = r_clr_ptr;
    w_key_ptr_next = r_key_ptr;
    w_mem_we       = 1'b0;
    w_mem_waddr    = r_clr_ptr;
    w_mem_wdata    = '0;
    unique case (r_state)
      StClear: begin
        w_mem_we       = 1'b1;
        w_clr_ptr_next = r_clr_ptr + 1'b1;
        if (r_clr_ptr == IdxW'(DEPTH - 1)) w_state_next = StProv;
      end
      StProv: begin
        w_mem_we       = 1'b1;
        w_mem_waddr    = IdxW'(KEY_BASE + r_key_ptr);
        w_mem_wdata    = KEY_VALUES[r_key_ptr*DATA_W +: DATA_W];
        w_key_ptr_next = r_key_ptr + 1'b1;
        if (r_key_ptr == KpW'(NUM_KEYS - 1)) w_state_next = StReady;
      end
      StReady: begin
        w_mem_we    = we && !w_oor && !w_is_key;
        w_mem_waddr = w_idx;
        w_mem_wdata = wd;
      end
      default: w_state_next = StClear;
    endcase
  end

  // Array is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out        <= '0;
      lock_violation  <= 1'b0;
      addr_err        <= 1'b0;
      violation_count <= '0;
    end else begin
      data_out       <= '0;
      lock_violation <= 1'b0;
      addr_err       <= 1'b0;
      if (ready) begin
        if (w_oor) begin
          addr_err <= 1'b1;
        end else begin
          if (!(w_is_key && (KEY_READABLE == 0))) data_out <= r_mem[w_idx];
          if (we && w_is_key) begin
            lock_violation <= 1'b1;
            if (violation_count != 8'hFF) violation_count <= violation_count + 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_key_locked_mem.sv
// Directed bench for key_locked_mem: default instance plus a KEY_READABLE=0 instance on the same bus.
module tb_key_locked_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        we;
  logic [31:0] wd;

  logic [31:0] data_out, nr_data_out;
  logic        ready, nr_ready;
  logic        lock_violation, nr_lock_violation;
  logic        addr_err, nr_addr_err;
  logic [7:0]  violation_count, nr_violation_count;

  int n_tests = 0;
  int n_fail  = 0;
  bit dout_nonzero;

  always #5 clk = ~clk;

  key_locked_mem u_dut (
    .clk             (clk),
    .reset           (reset),
    .address         (address),
    .we              (we),
    .wd              (wd),
    .data_out        (data_out),
    .ready           (ready),
    .lock_violation  (lock_violation),
    .addr_err        (addr_err),
    .violation_count (violation_count)
  );

  key_locked_mem #(.KEY_READABLE(0)) u_dut_nr (
    .clk             (clk),
    .reset           (reset),
    .address         (address),
    .we              (we),
    .wd              (wd),
    .data_out        (nr_data_out),
    .ready           (nr_ready),
    .lock_violation  (nr_lock_violation),
    .addr_err        (nr_addr_err),
    .violation_count (nr_violation_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges from reset release until ready, bounded.
  task automatic wait_ready(output int edges);
    edges = 0;
    dout_nonzero = 1'b0;
    while (!ready && edges < 200) begin
      tick();
      edges++;
      if (!ready && data_out != 32'h0) dout_nonzero = 1'b1;
    end
  endtask

  task automatic access(input logic [31:0] a, input logic w, input logic [31:0] d);
    address = a;
    we      = w;
    wd      = d;
    tick();
  endtask

  logic [31:0] exp_mem [32];
  int          edges;
  int          hi_cnt;

  initial begin
    reset   = 1'b0;
    address = 32'h0;
    we      = 1'b0;
    wd      = 32'h0;
    repeat (3) tick();
    check("rst_data_out", data_out, 32'h0);
    check("rst_ready", {31'h0, ready}, 32'h0);
    check("rst_lock", {31'h0, lock_violation}, 32'h0);
    check("rst_addr_err", {31'h0, addr_err}, 32'h0);
    check("rst_count", {24'h0, violation_count}, 32'h0);

    // 1. provisioning latency and key readback; host write during init must be ignored
    reset   = 1'b1;
    address = 32'h10;
    we      = 1'b1;
    wd      = 32'hCAFE_F00D;
    wait_ready(edges);
    we = 1'b0;
    check("ready_edges", edges, 34);
    check("init_data_out_zero", {31'h0, dout_nonzero}, 32'h0);
    check("init_no_violation", {24'h0, violation_count}, 32'h0);
    check("nr_ready", {31'h0, nr_ready}, 32'h1);
    access(32'h0, 1'b0, 32'h0);
    check("rd_key0", data_out, 32'h1035_9987);
    check("nr_rd_key0", nr_data_out, 32'h0);
    access(32'h4, 1'b0, 32'h0);
    check("rd_key1", data_out, 32'hA5A5_0F0F);
    access(32'h8, 1'b0, 32'h0);
    check("rd_word2", data_out, 32'h0);
    access(32'h10, 1'b0, 32'h0);
    check("init_write_ignored", data_out, 32'h0);

    // 2. blocked key write
    access(32'h0, 1'b1, 32'hDEAD_BEEF);
    check("kw_lock", {31'h0, lock_violation}, 32'h1);
    check("kw_count", {24'h0, violation_count}, 32'h1);
    check("kw_read_first", data_out, 32'h1035_9987);
    access(32'h0, 1'b0, 32'h0);
    check("kw_lock_drop", {31'h0, lock_violation}, 32'h0);
    check("kw_key_kept", data_out, 32'h1035_9987);

    // 3. normal word, we gating and read-first
    access(32'h10, 1'b0, 32'h5555_5555);
    check("we0_no_write", data_out, 32'h0);
    access(32'h12, 1'b1, 32'h1234_5678);
    check("wr_read_first", data_out, 32'h0);
    check("wr_no_lock", {31'h0, lock_violation}, 32'h0);
    access(32'h10, 1'b0, 32'h0);
    check("wr_readback", data_out, 32'h1234_5678);

    // 4. out-of-range accesses
    access(32'h80, 1'b1, 32'hFFFF_FFFF);
    check("oor_addr_err", {31'h0, addr_err}, 32'h1);
    check("oor_data_out", data_out, 32'h0);
    check("oor_no_lock", {31'h0, lock_violation}, 32'h0);
    access(32'h88, 1'b0, 32'h0);
    check("oor_we0_addr_err", {31'h0, addr_err}, 32'h1);
    access(32'h1_0088, 1'b1, 32'hFFFF_FFFF);
    check("oor_high_addr_err", {31'h0, addr_err}, 32'h1);
    access(32'h8, 1'b0, 32'h0);
    check("oor_pulse_end", {31'h0, addr_err}, 32'h0);
    check("oor_count", {24'h0, violation_count}, 32'h1);
    for (int i = 0; i < 32; i++) exp_mem[i] = 32'h0;
    exp_mem[0] = 32'h1035_9987;
    exp_mem[1] = 32'hA5A5_0F0F;
    exp_mem[4] = 32'h1234_5678;
    for (int i = 0; i < 32; i++) begin
      access(32'(i * 4), 1'b0, 32'h0);
      check($sformatf("scan_%0d", i), data_out, exp_mem[i]);
    end

    // 5. sustained key writes saturate the counter
    hi_cnt = 0;
    address = 32'h4;
    we      = 1'b1;
    wd      = 32'h0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (lock_violation) hi_cnt++;
    end
    check("sat_lock_cycles", hi_cnt, 300);
    check("sat_count", {24'h0, violation_count}, 32'hFF);
    access(32'h4, 1'b0, 32'h0);
    check("sat_lock_drop", {31'h0, lock_violation}, 32'h0);
    check("sat_key_kept", data_out, 32'hA5A5_0F0F);

    // 6. reset in READY, then again mid-CLEAR
    reset = 1'b0;
    #1;
    check("rr_count_clr", {24'h0, violation_count}, 32'h0);
    check("rr_ready_clr", {31'h0, ready}, 32'h0);
    tick();
    reset = 1'b1;
    repeat (10) tick();
    reset = 1'b0;
    #1;
    check("mid_ready", {31'h0, ready}, 32'h0);
    tick();
    reset = 1'b1;
    wait_ready(edges);
    check("mid_ready_edges", edges, 34);
    access(32'h10, 1'b0, 32'h0);
    check("mid_word_cleared", data_out, 32'h0);
    access(32'h0, 1'b0, 32'h0);
    check("mid_key0", data_out, 32'h1035_9987);
    check("mid_nr_key0", nr_data_out, 32'h0);
    access(32'h4, 1'b0, 32'h0);
    check("mid_nr_key1", nr_data_out, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_locked_mem.md
Name: key_locked_mem

Overview:
- Parametrised word-addressed memory with a block of immutable key slots.
- After reset, an internal FSM clears the array and provisions the key slots from parameters.
- In operation, host writes to key slots are blocked, counted and flagged; writes require `we`.
- Sits on the simple address/we/wd bus used by the security example blocks. It is the parametrised successor of the single-key protected memory.

Parameters:
- DATA_W, 32, word width.
- DEPTH, 32, number of words; power of 2, at least 4.
- ADDR_W, 32, byte-address width.
- NUM_KEYS, 2, number of immutable slots; 1..DEPTH.
- KEY_BASE, 0, first key word index; KEY_BASE+NUM_KEYS <= DEPTH.
- KEY_VALUES, {32'hA5A5_0F0F, 32'h1035_9987}, NUM_KEYS*DATA_W packed; slice k is the value for slot KEY_BASE+k.
- KEY_READABLE, 1, 0 = reads of key slots return 0.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- address  in  ADDR_W  byte address; IDX = address[log2(DEPTH)+1:2]; address[1:0] ignored
- we  in  1  write enable
- wd  in  DATA_W  write data
- data_out  out  DATA_W  registered read data
- ready  out  1  high once provisioning completes
- lock_violation  out  1  one-cycle pulse for a blocked key-slot write
- addr_err  out  1  one-cycle pulse for an access with out-of-range upper address bits
- violation_count  out  8  saturating count of blocked key writes

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - FSM = CLEAR, clr_ptr = 0, key_ptr = 0
  - data_out = 0, ready = 0, lock_violation = 0, addr_err = 0, violation_count = 0
  - The array itself is not reset.
- CLEAR: each cycle writes mem[clr_ptr] = 0 and increments clr_ptr. At clr_ptr = DEPTH-1 the FSM moves to PROV.
- PROV: each cycle writes mem[KEY_BASE+key_ptr] = KEY_VALUES slice key_ptr. At key_ptr = NUM_KEYS-1 the FSM moves to READY.
- Timing: ready rises exactly DEPTH+NUM_KEYS rising edges after reset deasserts and stays high until the next reset.
- While not READY:
  - Host writes and reads are ignored.
  - data_out holds 0.
  - No violation or addr_err is reported.
- READY, out-of-range access (any bit address[ADDR_W-1:log2(DEPTH)+2] set):
  - Write is dropped.
  - data_out <= 0 at the next edge.
  - addr_err pulses at the next edge, whether or not we is set.
- READY, in-range, IDX in [KEY_BASE, KEY_BASE+NUM_KEYS-1] with we=1:
  - Write is dropped.
  - lock_violation pulses at the next edge.
  - violation_count increments and saturates at 255.
- READY, in-range, non-key IDX with we=1: mem[IDX] <= wd at the edge.
- we=0: memory is never modified, for any address.
- Reads (READY, in-range): data_out <= mem[IDX] at each edge; latency 1 cycle.
  - Read-first: a same-cycle write returns the old word; the new word is visible on the next access.
  - If KEY_READABLE=0, key-slot reads give data_out <= 0.
- Pulse rules: lock_violation and addr_err are registered and last exactly one cycle per offending access. Back-to-back offending cycles hold the pulse high for consecutive cycles.
- Reset mid-CLEAR or mid-PROV: the FSM restarts at CLEAR with clr_ptr = 0, and the full sequence is repeated.
- Reset in READY also clears violation_count.

Test Plan (DEPTH=32, NUM_KEYS=2, KEY_BASE=0, defaults):
1. Release reset, hold we=0 -> ready rises after exactly 34 edges; data_out=0 throughout. Then read 0x0 -> 0x10359987, read 0x4 -> 0xA5A50F0F, read 0x8 -> 0x00000000.
2. READY, address 0x0, we=1, wd=0xDEADBEEF -> lock_violation pulses one cycle, violation_count=1. A later read of 0x0 returns 0x10359987.
3. address 0x10, we=0, wd=0x55555555 -> read 0x10 returns 0. Then we=1, wd=0x12345678 -> data_out=0 on that edge (read-first), next read of 0x10 returns 0x12345678, no violation.
4. address 0x80, we=1 -> addr_err pulses, data_out=0, the 32 words are unchanged, violation_count unchanged.
5. 300 consecutive writes to 0x4 -> lock_violation high for 300 cycles, violation_count stops at 255, key still 0xA5A50F0F.
6. Assert reset at cycle 10 of CLEAR, then release -> ready rises 34 edges after release; the previous write of 0x12345678 to 0x10 reads back 0; with KEY_READABLE=0, read 0x0 -> 0.
